fetch_queue: RTL
================

# fetch_queue

In-order instruction queue between the fetch stage and decode. It reserves one slot per issued imem request and captures that request's pc/order. It fills the slot when the in-order imem response returns, then presents completed instructions to decode over a valid/ready handshake. It also generates `do_fetch` back-pressure to fetch, and on `flush` it discards queued and in-flight instructions.

## Interface
- `DEPTH`, 8: number of slots; power of two, ≥2.
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `flush`  in  1: redirect; discard all slots and in-flight responses.
- `do_fetch`  out  1: fetch may issue a request this cycle.
- `imem_rqst`  in  1: fetch issued a request this cycle; only legal when `do_fetch`=1.
- `fetch_pc`  in  32: pc of the request issued this cycle.
- `fetch_order`  in  64: order of the request issued this cycle.
- `imem_rdata`  in  32: instruction word of the returning response.
- `imem_resp`  in  1: one response returns this cycle; responses return in request order, ≥1 cycle after their request.
- `deq_valid`  out  1: head slot holds a filled instruction.
- `deq_ready`  in  1: decode accepts the head this cycle.
- `deq_inst`  out  32: head instruction.
- `deq_pc`  out  32: head pc.
- `deq_order`  out  64: head order.

## Operation
- Pointers `head`, `fill`, `tail` are each log2(DEPTH)+1 bits wide; the extra MSB disambiguates full from empty. Slots `[fill, tail)` are reserved but not yet filled; slots `[head, fill)` are filled.
- `count` = `tail` − `head` (modular). `pending` = `tail` − `fill`.
- `drop_cnt` is log2(DEPTH)+1 bits wide. It counts in-flight responses that belong to flushed requests.
- `do_fetch` = !`rst` && !`flush` && (`count` + `drop_cnt` < DEPTH). This bound keeps total in-flight requests ≤ DEPTH, so `drop_cnt` never overflows.
- Enqueue on `imem_rqst`: write pc/order into slot `tail`, clear its filled bit, then `tail`++.
- Response handling on `imem_resp`:
  - If `drop_cnt` > 0: discard the response and decrement `drop_cnt`.
  - Otherwise: write `imem_rdata` to slot `fill`, set its filled bit, then `fill`++.
- `deq_valid` = (`head` ≠ `fill`) && !`flush`. The `deq_*` fields are read combinationally from slot `head`. On `deq_valid` && `deq_ready`, `head`++.
- Flush, as a single update:
  - `head` = `fill` = `tail` = 0.
  - `drop_cnt` ← `drop_cnt` + `pending` − `imem_resp`. This one formula covers both response cases in the flush cycle.
  - Any enqueue or dequeue in the flush cycle is ignored.
- Enqueue, fill and dequeue may all occur in the same cycle, each on its own slot.
- `imem_rqst` while `do_fetch`=0, or `imem_resp` with `pending` + `drop_cnt` = 0, is a protocol violation. The bench asserts on it; the RTL behaviour is undefined.

## Timing
- Reset values: all pointers 0, `drop_cnt` 0, all filled bits 0. Outputs: `deq_valid` 0, `do_fetch` 0 while `rst` is high and 1 on the first cycle after release. `deq_inst`, `deq_pc` and `deq_order` read slot 0.
- Response in cycle N → `deq_valid`=1 in cycle N+1 if that slot is at the head. There is no bypass from response to dequeue.
- Dequeue in cycle N frees a slot, so `do_fetch` can rise in N+1. `do_fetch` depends combinationally only on `flush` and registered state, never on `imem_rqst`.
- A flush in cycle N gives empty queue state in N+1. `do_fetch`=0 in N; in N+1 it is 1 iff `drop_cnt` < DEPTH.
- Reset asserted mid-operation immediately clears all state, including `drop_cnt`. Responses still in flight across a reset are the memory model's responsibility and are not dropped.

## Structure
- `fetch_pkg` holds:
  - `fetch_entry_t`: `inst[31:0]`, `pc[31:0]`, `order[63:0]`, `filled`.
  - `RESET_PC` = 32'h1ECEB000, shared with the fetch stage.
- Slot storage is a flop array of `fetch_entry_t` (no SRAM). Pointers and `drop_cnt` are flops with asynchronous reset.
- No sub-module; the control logic is small enough to live inline.

## Test plan
- **Single fetch:** request pc 1ECEB000, order 0; response 00000013 two cycles later → `deq_valid` the next cycle with inst 00000013, pc 1ECEB000, order 0.
- **Fill to full:** 8 requests with no responses → `do_fetch`=0 after the 8th. Return 8 responses, then dequeue 1 → `do_fetch`=1 the next cycle. Order stays 0..7 in sequence.
- **Flush with in-flight requests:** 3 outstanding and 1 filled; flush → `drop_cnt`=3. The next 3 responses are discarded and the 4th lands in slot 0 with its new pc/order.
- **Flush coinciding with a response:** `pending`=2, `drop_cnt`=0, `imem_resp` and `flush` in the same cycle → `drop_cnt`=1, queue empty, `deq_valid`=0.
- **Back-to-back streaming:** enqueue, fill and dequeue every cycle for 40 cycles across pointer wrap → no loss or duplication, order strictly increments, `count` steady.
- **Async reset:** assert `rst` mid-stream, off a clock edge → `deq_valid` and `do_fetch` drop immediately. After release, the queue is empty and `drop_cnt`=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/decode boundary.
package fetch_pkg;

    // One queue slot: captured request info plus the returned instruction word.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] order;
        logic        filled;
    } fetch_entry_t;

    // First pc fetched after reset; also used by the fetch stage.
    localparam logic [31:0] RESET_PC = 32'h1ECEB000;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: reserves a slot per imem request, fills it when the
// in-order response returns and hands completed instructions to decode.
// Responses belonging to flushed requests are counted and discarded.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    output logic        do_fetch,
    input  logic        imem_rqst,
    input  logic [31:0] fetch_pc,
    input  logic [63:0] fetch_order,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_inst,
    output logic [31:0] deq_pc,
    output logic [63:0] deq_order
);

    localparam int unsigned IW = $clog2(DEPTH);
    // Extra MSB distinguishes full from empty.
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] drop_q, drop_d;

    fetch_entry_t slots_q [DEPTH];
    fetch_entry_t head_entry;

    logic [PW-1:0] count;
    logic [PW-1:0] pending;
    logic [PW:0]   inflight;
    logic          enq;
    logic          take_resp;
    logic          drop_resp;
    logic          deq;

    assign count    = tail_q - head_q;
    assign pending  = tail_q - fill_q;
    // Slots in use plus responses still owed for flushed requests.
    assign inflight = {1'b0, count} + {1'b0, drop_q};

    assign head_entry = slots_q[head_q[IW-1:0]];

    assign do_fetch  = !rst && !flush && (inflight < (PW + 1)'(DEPTH));
    assign deq_valid = (head_q != fill_q) && head_entry.filled && !flush;
    assign deq_inst  = head_entry.inst;
    assign deq_pc    = head_entry.pc;
    assign deq_order = head_entry.order;

    assign enq       = imem_rqst && !flush;
    assign take_resp = imem_resp && !flush && (drop_q == '0);
    assign drop_resp = imem_resp && !flush && (drop_q != '0);
    assign deq       = deq_valid && deq_ready;

    // Next-state for pointers and the stale-response counter.
    always_comb begin
        head_d = head_q;
        fill_d = fill_q;
        tail_d = tail_q;
        drop_d = drop_q;
        if (flush) begin
            head_d = '0;
            fill_d = '0;
            tail_d = '0;
            // Every unfilled reservation becomes a response to drop; a response
            // arriving this cycle pays off one of them immediately.
            drop_d = drop_q + pending - PW'(imem_resp);
        end else begin
            if (enq) begin
                tail_d = tail_q + PW'(1);
            end
            if (take_resp) begin
                fill_d = fill_q + PW'(1);
            end
            if (drop_resp) begin
                drop_d = drop_q - PW'(1);
            end
            if (deq) begin
                head_d = head_q + PW'(1);
            end
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
            drop_q <= '0;
        end else begin
            head_q <= head_d;
            fill_q <= fill_d;
            tail_q <= tail_d;
            drop_q <= drop_d;
        end
    end

    // Slot storage: enqueue captures pc/order, a kept response fills the inst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            if (enq) begin
                slots_q[tail_q[IW-1:0]].pc     <= fetch_pc;
                slots_q[tail_q[IW-1:0]].order  <= fetch_order;
                slots_q[tail_q[IW-1:0]].filled <= 1'b0;
            end
            if (take_resp) begin
                slots_q[fill_q[IW-1:0]].inst   <= imem_rdata;
                slots_q[fill_q[IW-1:0]].filled <= 1'b1;
            end
        end
    end

endmodule
